// File: rtl/mipi_csi_rx_lane_deskew.sv
// CSI-2 RX lane deskew: measures per-lane arrival skew at packet start and delays early lanes
// so all lanes present the sync word together. Optional stats ports: MIPI_RX_DESKEW_STATS_EN.
module mipi_csi_rx_lane_deskew #(
  parameter int unsigned MIPI_GEAR  = 8,
  parameter int unsigned MIPI_LANES = 2,
  parameter int unsigned MAX_SKEW   = 4,
  localparam int unsigned OFFW = (MAX_SKEW > 1) ? $clog2(MAX_SKEW) : 1,
  localparam int unsigned W    = MIPI_GEAR * MIPI_LANES
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [MIPI_LANES-1:0]      bytes_valid_i,
  input  logic [W-1:0]               byte_i,
  output logic                       lane_valid_o,
  output logic [W-1:0]               lane_byte_o,
`ifdef MIPI_RX_DESKEW_STATS_EN
  output logic [MIPI_LANES*OFFW-1:0] lane_offset_o,
  output logic [7:0]                 skew_err_cnt_o,
`endif
  output logic                       skew_err_o
);

  // Tap 0 is the live input, so only MAX_SKEW-1 stages need storage.
  localparam int unsigned DEPTH = MAX_SKEW - 1;

  typedef enum logic [1:0] {StIdle, StArrive, StLocked, StWaitIdle} state_e;

  state_e                           state_q, state_d;
  logic [OFFW-1:0]                  arr_cnt_q, arr_cnt_d;
  logic [MIPI_LANES-1:0]            arrived_q, arrived_d, arrived_nxt;
  logic [MIPI_LANES-1:0][OFFW-1:0]  arrival_q, arrival_d, arrival_nxt;
  logic [MIPI_LANES-1:0][OFFW-1:0]  delay_q, delay_d, delay_new, delay_sel;
  logic [DEPTH-1:0][MIPI_LANES-1:0] dl_v_q, dl_v_d;
  logic [DEPTH-1:0][W-1:0]          dl_d_q, dl_d_d;
  logic                             idle_prev_q, idle_prev_d;
  logic                             lane_valid_q, lane_valid_d;
  logic [W-1:0]                     lane_byte_q, lane_byte_d;
  logic                             skew_err_q, skew_err_d;
  logic [MIPI_LANES-1:0]            tap_v;
  logic [W-1:0]                     tap_data;
  logic [OFFW-1:0]                  max_arr;
`ifdef MIPI_RX_DESKEW_STATS_EN
  logic [7:0]                       err_cnt_q, err_cnt_d;
`endif

  always_comb begin
    dl_v_d[0] = bytes_valid_i;
    dl_d_d[0] = byte_i;
    for (int k = 1; k < DEPTH; k++) begin
      dl_v_d[k] = dl_v_q[k-1];
      dl_d_d[k] = dl_d_q[k-1];
    end
  end

  // Arrival bookkeeping including this cycle's valids, so a packet can lock in the same cycle.
  always_comb begin
    arrived_nxt = '0;
    arrival_nxt = '0;
    max_arr     = '0;
    if (state_q == StIdle) begin
      arrived_nxt = bytes_valid_i;
    end else begin
      arrived_nxt = arrived_q | bytes_valid_i;
      for (int i = 0; i < MIPI_LANES; i++) begin
        arrival_nxt[i] = arrived_q[i] ? arrival_q[i] : (bytes_valid_i[i] ? arr_cnt_q : '0);
      end
    end
    for (int i = 0; i < MIPI_LANES; i++) begin
      if (arrival_nxt[i] > max_arr) max_arr = arrival_nxt[i];
    end
    for (int i = 0; i < MIPI_LANES; i++) begin
      delay_new[i] = max_arr - arrival_nxt[i];
    end
  end

  always_comb begin
    delay_sel = (state_q == StLocked) ? delay_q : delay_new;
    tap_v     = '0;
    tap_data  = '0;
    for (int i = 0; i < MIPI_LANES; i++) begin
      tap_v[i] = bytes_valid_i[i];
      tap_data[i*MIPI_GEAR +: MIPI_GEAR] = byte_i[i*MIPI_GEAR +: MIPI_GEAR];
      for (int k = 1; k < MAX_SKEW; k++) begin
        if (delay_sel[i] == OFFW'(k)) begin
          tap_v[i] = dl_v_q[k-1][i];
          tap_data[i*MIPI_GEAR +: MIPI_GEAR] = dl_d_q[k-1][i*MIPI_GEAR +: MIPI_GEAR];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    arr_cnt_d    = arr_cnt_q;
    arrived_d    = arrived_q;
    arrival_d    = arrival_q;
    delay_d      = delay_q;
    lane_valid_d = 1'b0;
    lane_byte_d  = lane_byte_q;
    skew_err_d   = 1'b0;
    // A packet may only start after an all-idle cycle, so a reset mid-packet skips the tail.
    idle_prev_d  = ~|bytes_valid_i;
    unique case (state_q)
      StIdle: begin
        arrived_d = '0;
        arrival_d = '0;
        if (idle_prev_q && |bytes_valid_i) begin
          arrived_d = arrived_nxt;
          arr_cnt_d = OFFW'(1);
          if (&bytes_valid_i) begin
            delay_d      = delay_new;
            lane_valid_d = 1'b1;
            lane_byte_d  = tap_data;
            state_d      = StLocked;
          end else begin
            state_d = StArrive;
          end
        end
      end
      StArrive: begin
        arr_cnt_d = arr_cnt_q + OFFW'(1);
        arrived_d = arrived_nxt;
        arrival_d = arrival_nxt;
        if (|(arrived_q & ~bytes_valid_i)) begin
          skew_err_d = 1'b1;
          state_d    = StWaitIdle;
        end else if (&arrived_nxt) begin
          delay_d      = delay_new;
          lane_valid_d = 1'b1;
          lane_byte_d  = tap_data;
          state_d      = StLocked;
        end else if (arr_cnt_q == OFFW'(MAX_SKEW - 1)) begin
          skew_err_d = 1'b1;
          state_d    = StWaitIdle;
        end
      end
      StLocked: begin
        if (&tap_v) begin
          lane_valid_d = 1'b1;
          lane_byte_d  = tap_data;
        end else begin
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (bytes_valid_i == '0 && dl_v_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef MIPI_RX_DESKEW_STATS_EN
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (skew_err_d && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      arr_cnt_q    <= '0;
      arrived_q    <= '0;
      arrival_q    <= '0;
      delay_q      <= '0;
      dl_v_q       <= '0;
      dl_d_q       <= '0;
      idle_prev_q  <= 1'b0;
      lane_valid_q <= 1'b0;
      lane_byte_q  <= '0;
      skew_err_q   <= 1'b0;
`ifdef MIPI_RX_DESKEW_STATS_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      arr_cnt_q    <= arr_cnt_d;
      arrived_q    <= arrived_d;
      arrival_q    <= arrival_d;
      delay_q      <= delay_d;
      dl_v_q       <= dl_v_d;
      dl_d_q       <= dl_d_d;
      idle_prev_q  <= idle_prev_d;
      lane_valid_q <= lane_valid_d;
      lane_byte_q  <= lane_byte_d;
      skew_err_q   <= skew_err_d;
`ifdef MIPI_RX_DESKEW_STATS_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign lane_valid_o = lane_valid_q;
  assign lane_byte_o  = lane_byte_q;
  assign skew_err_o   = skew_err_q;
`ifdef MIPI_RX_DESKEW_STATS_EN
  assign lane_offset_o  = delay_q;
  assign skew_err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_mipi_csi_rx_lane_deskew.sv
// Directed bench for mipi_csi_rx_lane_deskew (GEAR=8, LANES=2, MAX_SKEW=4).
module tb_mipi_csi_rx_lane_deskew;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  bv = '0;
  logic [15:0] bi = '0;
  logic        lv;
  logic [15:0] lb;
  logic        se;
`ifdef MIPI_RX_DESKEW_STATS_EN
  logic [3:0]  lo;
  logic [7:0]  sc;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mipi_csi_rx_lane_deskew #(
    .MIPI_GEAR (8),
    .MIPI_LANES(2),
    .MAX_SKEW  (4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .bytes_valid_i (bv),
    .byte_i        (bi),
    .lane_valid_o  (lv),
    .lane_byte_o   (lb),
`ifdef MIPI_RX_DESKEW_STATS_EN
    .lane_offset_o (lo),
    .skew_err_cnt_o(sc),
`endif
    .skew_err_o    (se)
  );

  // Apply inputs, then return 1 time unit after the edge that samples them.
  task automatic drive(input logic [1:0] v, input logic [15:0] d);
    bv = v;
    bi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 16'h0000);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(2'b00, 16'h0000);
    drive(2'b11, 16'hffff);
    total++; if (lv !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", lv); end
    total++; if (lb !== 16'h0) begin bad++; $display("FAIL reset_byte: got %h want 0000", lb); end
    total++; if (se !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", se); end
`ifdef MIPI_RX_DESKEW_STATS_EN
    total++; if (lo !== 4'h0) begin bad++; $display("FAIL reset_offset: got %h want 0", lo); end
    total++; if (sc !== 8'h0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", sc); end
`endif
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_lane0_leads;
    logic [1:0]  v  [9] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [15:0] d  [9] = '{16'h00b8, 16'hb811, 16'h1122, 16'h2233, 16'h3344, 16'h4455,
                            16'h5566, 16'h6600, 16'h0000};
    logic        ev [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ed [9] = '{16'h0000, 16'hb8b8, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                            16'h5555, 16'h6666, 16'h6666};
    for (int k = 0; k < 9; k++) begin
      drive(v[k], d[k]);
      total++; if (lv !== ev[k]) begin bad++; $display("FAIL l0lead_valid[%0d]: got %b want %b", k, lv, ev[k]); end
      if (k > 0) begin
        total++; if (lb !== ed[k]) begin bad++; $display("FAIL l0lead_byte[%0d]: got %h want %h", k, lb, ed[k]); end
      end
      total++; if (se !== 1'b0) begin bad++; $display("FAIL l0lead_err[%0d]: got %b want 0", k, se); end
    end
`ifdef MIPI_RX_DESKEW_STATS_EN
    total++; if (lo !== 4'b0001) begin bad++; $display("FAIL l0lead_offset: got %b want 0001", lo); end
`endif
    idle(6);
  endtask

  task automatic test_aligned;
    logic [15:0] w;
    for (int k = 0; k < 8; k++) begin
      w = (k == 0) ? 16'hb8b8 : 16'(k * 16'h1111);
      drive(2'b11, w);
      total++; if (lv !== 1'b1) begin bad++; $display("FAIL aligned_valid[%0d]: got %b want 1", k, lv); end
      total++; if (lb !== w) begin bad++; $display("FAIL aligned_byte[%0d]: got %h want %h", k, lb, w); end
    end
    drive(2'b00, 16'h0000);
    total++; if (lv !== 1'b0) begin bad++; $display("FAIL aligned_fall: got %b want 0", lv); end
    total++; if (lb !== 16'h7777) begin bad++; $display("FAIL aligned_hold: got %h want 7777", lb); end
`ifdef MIPI_RX_DESKEW_STATS_EN
    total++; if (lo !== 4'b0000) begin bad++; $display("FAIL aligned_offset: got %b want 0000", lo); end
`endif
    idle(6);
  endtask

  task automatic test_lane1_leads2;
    logic [1:0]  v  [10] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01,
                             2'b00};
    logic [15:0] d  [10] = '{16'hb800, 16'h1100, 16'h22b8, 16'h3311, 16'h4422, 16'h5533,
                             16'h6644, 16'h0055, 16'h0066, 16'h0000};
    logic        ev [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ed [10] = '{16'h0000, 16'h0000, 16'hb8b8, 16'h1111, 16'h2222, 16'h3333,
                             16'h4444, 16'h5555, 16'h6666, 16'h6666};
    for (int k = 0; k < 10; k++) begin
      drive(v[k], d[k]);
      total++; if (lv !== ev[k]) begin bad++; $display("FAIL l1lead_valid[%0d]: got %b want %b", k, lv, ev[k]); end
      if (k >= 2) begin
        total++; if (lb !== ed[k]) begin bad++; $display("FAIL l1lead_byte[%0d]: got %h want %h", k, lb, ed[k]); end
      end
      total++; if (se !== 1'b0) begin bad++; $display("FAIL l1lead_err[%0d]: got %b want 0", k, se); end
    end
`ifdef MIPI_RX_DESKEW_STATS_EN
    total++; if (lo !== 4'b1000) begin bad++; $display("FAIL l1lead_offset: got %b want 1000", lo); end
`endif
    idle(6);
  endtask

  task automatic test_skew_timeout;
    logic ee [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(2'b10, 16'haa00);
      total++; if (se !== ee[k]) begin bad++; $display("FAIL timeout_err[%0d]: got %b want %b", k, se, ee[k]); end
      total++; if (lv !== 1'b0) begin bad++; $display("FAIL timeout_valid[%0d]: got %b want 0", k, lv); end
    end
    drive(2'b00, 16'h0000);
    total++; if (se !== 1'b0) begin bad++; $display("FAIL timeout_pulse_end: got %b want 0", se); end
    idle(6);
    drive(2'b11, 16'ha1a1);
    total++; if (lv !== 1'b1 || lb !== 16'ha1a1) begin bad++; $display("FAIL timeout_relock: got %b/%h want 1/a1a1", lv, lb); end
    drive(2'b11, 16'ha2a2);
    total++; if (lv !== 1'b1 || lb !== 16'ha2a2) begin bad++; $display("FAIL timeout_relock2: got %b/%h want 1/a2a2", lv, lb); end
    idle(6);
  endtask

  task automatic test_dropout;
    drive(2'b10, 16'hab00);
    total++; if (se !== 1'b0) begin bad++; $display("FAIL dropout_early: got %b want 0", se); end
    drive(2'b00, 16'h0000);
    total++; if (se !== 1'b1) begin bad++; $display("FAIL dropout_err: got %b want 1", se); end
    drive(2'b00, 16'h0000);
    total++; if (se !== 1'b0) begin bad++; $display("FAIL dropout_pulse_end: got %b want 0", se); end
    total++; if (lv !== 1'b0) begin bad++; $display("FAIL dropout_valid: got %b want 0", lv); end
    idle(6);
  endtask

  task automatic test_reset_mid_packet;
    drive(2'b11, 16'hc1c1);
    drive(2'b11, 16'hc2c2);
    drive(2'b11, 16'hc3c3);
    total++; if (lv !== 1'b1 || lb !== 16'hc3c3) begin bad++; $display("FAIL midrst_pre: got %b/%h want 1/c3c3", lv, lb); end
    reset = 1'b1;
    drive(2'b11, 16'hc4c4);
    reset = 1'b0;
    total++; if (lv !== 1'b0 || lb !== 16'h0000) begin bad++; $display("FAIL midrst_clear: got %b/%h want 0/0000", lv, lb); end
    drive(2'b11, 16'hc5c5);
    total++; if (lv !== 1'b0) begin bad++; $display("FAIL midrst_ignore1: got %b want 0", lv); end
    drive(2'b11, 16'hc6c6);
    total++; if (lv !== 1'b0) begin bad++; $display("FAIL midrst_ignore2: got %b want 0", lv); end
    idle(4);
    drive(2'b11, 16'hd1d1);
    total++; if (lv !== 1'b1 || lb !== 16'hd1d1) begin bad++; $display("FAIL midrst_relock: got %b/%h want 1/d1d1", lv, lb); end
    drive(2'b00, 16'h0000);
    total++; if (lv !== 1'b0) begin bad++; $display("FAIL midrst_end: got %b want 0", lv); end
    idle(6);
  endtask

`ifdef MIPI_RX_DESKEW_STATS_EN
  task automatic test_err_count;
    reset = 1'b1;
    drive(2'b00, 16'h0000);
    reset = 1'b0;
    idle(2);
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) drive(2'b10, 16'h5500);
      idle(6);
    end
    total++; if (sc !== 8'd3) begin bad++; $display("FAIL err_count: got %0d want 3", sc); end
  endtask
`endif

  initial begin
    test_reset;
    test_lane0_leads;
    test_aligned;
    test_lane1_leads2;
    test_skew_timeout;
    test_dropout;
    test_reset_mid_packet;
`ifdef MIPI_RX_DESKEW_STATS_EN
    test_err_count;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
